// File: rtl/irda_dma_pkg.sv
// Shared types and constants for the IrDA DMA controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package irda_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_TX_RD_MEM,
    ST_TX_WR_CORE,
    ST_RX_RD_CORE,
    ST_RX_WR_MEM,
    ST_ACK,
    ST_HOLD
  } dma_state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADDR_INC   = 32'd4;

  // Memory-bus master request bundle.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } mem_req_t;

  // Core-slave-port master request bundle.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
  } core_req_t;

  // Memory pointers are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/irda_dma_chan.sv
// One DMA channel: word pointer, remaining count, armed flag and done pulse.
// Latency: start/step/abort take effect on the next clock edge; done is one cycle after the last step.
// Backpressure: none; a start while armed is dropped, step/abort are only issued while armed.
// Ports: start/base/len arm the channel, req+busy form eligible, step advances
// ptr/rem after each acknowledged word, abort disarms without a done pulse.
module irda_dma_chan
  import irda_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  input  logic             req,
  input  logic             step,
  input  logic             abort,
  output logic             accept,
  output logic             eligible,
  output logic             busy,
  output logic             done,
  output logic [31:0]      ptr
);

  logic [LEN_W-1:0] rem;

  assign accept   = start & ~busy;
  assign eligible = busy & req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      rem  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ptr  <= word_align(base);
        rem  <= len;
        // A zero-length job never arms; it just reports completion.
        busy <= (len != '0);
        done <= (len == '0);
      end else if (abort) begin
        busy <= 1'b0;
      end else if (step) begin
        ptr <= ptr + ADDR_INC;
        rem <= rem - LEN_W'(1);
        if (rem == LEN_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irda_dma_ctrl.sv
// Two-channel, one-engine DMA between system memory and the IrDA core FIFO register.
// Latency: 5 cycles from request sampled in ARB to dma_ack with slaves that ack one cycle after strobe.
// Backpressure: strobes are held until the slave acks (no timeout); a memory error aborts the channel.
// Ports: wb_clk_i/wb_rst_i (async, active-low); per-channel start/base/len config,
// dma_req/dma_ack core handshake, m_* memory master, c_* core master, busy/done/err status.
module irda_dma_ctrl
  import irda_dma_pkg::*;
#(
  parameter int         LEN_W    = 16,
  parameter logic [3:0] FIFO_ADR = 4'h0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             tx_start_i,
  input  logic [31:0]      tx_base_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic             rx_start_i,
  input  logic [31:0]      rx_base_i,
  input  logic [LEN_W-1:0] rx_len_i,
  input  logic             dma_req_t_i,
  input  logic             dma_req_r_i,
  output logic             dma_ack_t_o,
  output logic             dma_ack_r_o,
  output logic [31:0]      m_adr_o,
  output logic [31:0]      m_dat_o,
  input  logic [31:0]      m_dat_i,
  output logic             m_we_o,
  output logic [3:0]       m_sel_o,
  output logic             m_stb_o,
  output logic             m_cyc_o,
  input  logic             m_ack_i,
  input  logic             m_err_i,
  output logic [3:0]       c_adr_o,
  output logic [31:0]      c_dat_o,
  input  logic [31:0]      c_dat_i,
  output logic             c_we_o,
  output logic             c_stb_o,
  output logic             c_cyc_o,
  input  logic             c_ack_i,
  output logic             tx_busy_o,
  output logic             rx_busy_o,
  output logic             tx_done_o,
  output logic             rx_done_o,
  output logic             err_o
);

  dma_state_t  state;
  logic        grant_rx;
  mem_req_t    mreq;
  core_req_t   creq;
  logic        ack_t, ack_r, err;

  logic        tx_accept, rx_accept, tx_elig, rx_elig;
  logic        tx_step, rx_step, tx_abort, rx_abort;
  logic [31:0] tx_ptr, rx_ptr;

  // Channels advance while the ack pulse is out, so a start landing on the
  // final ACK cycle still sees the channel busy and is dropped.
  assign tx_step  = (state == ST_ACK) & ~grant_rx;
  assign rx_step  = (state == ST_ACK) &  grant_rx;
  assign tx_abort = (state == ST_TX_RD_MEM) & m_err_i;
  assign rx_abort = (state == ST_RX_WR_MEM) & m_err_i;

  irda_dma_chan #(.LEN_W(LEN_W)) u_tx (
    .clk(wb_clk_i), .rst_n(wb_rst_i),
    .start(tx_start_i), .base(tx_base_i), .len(tx_len_i), .req(dma_req_t_i),
    .step(tx_step), .abort(tx_abort),
    .accept(tx_accept), .eligible(tx_elig), .busy(tx_busy_o), .done(tx_done_o), .ptr(tx_ptr)
  );

  irda_dma_chan #(.LEN_W(LEN_W)) u_rx (
    .clk(wb_clk_i), .rst_n(wb_rst_i),
    .start(rx_start_i), .base(rx_base_i), .len(rx_len_i), .req(dma_req_r_i),
    .step(rx_step), .abort(rx_abort),
    .accept(rx_accept), .eligible(rx_elig), .busy(rx_busy_o), .done(rx_done_o), .ptr(rx_ptr)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= ST_IDLE;
      grant_rx <= 1'b0;
      mreq     <= '0;
      creq     <= '0;
      ack_t    <= 1'b0;
      ack_r    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_t <= 1'b0;
      ack_r <= 1'b0;
      // An accepted start clears the sticky error; a same-cycle abort below wins.
      if (tx_accept || rx_accept) err <= 1'b0;
      unique case (state)
        ST_IDLE: state <= ST_ARB;
        ST_ARB: begin
          // RX first: an unserviced RX FIFO overruns, a TX FIFO only idles.
          if (rx_elig) begin
            grant_rx <= 1'b1;
            creq     <= '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: FIFO_ADR, dat: 32'h0};
            state    <= ST_RX_RD_CORE;
          end else if (tx_elig) begin
            grant_rx <= 1'b0;
            mreq     <= '{cyc: 1'b1, stb: 1'b1, we: 1'b0, sel: WB_SEL_ALL, adr: tx_ptr, dat: 32'h0};
            state    <= ST_TX_RD_MEM;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_TX_RD_MEM: begin
          if (m_err_i) begin
            mreq.cyc <= 1'b0; mreq.stb <= 1'b0; mreq.sel <= '0;
            err      <= 1'b1;
            state    <= ST_IDLE;
          end else if (m_ack_i) begin
            mreq.cyc <= 1'b0; mreq.stb <= 1'b0; mreq.sel <= '0;
            creq     <= '{cyc: 1'b1, stb: 1'b1, we: 1'b1, adr: FIFO_ADR, dat: m_dat_i};
            state    <= ST_TX_WR_CORE;
          end
        end
        ST_TX_WR_CORE: begin
          if (c_ack_i) begin
            creq.cyc <= 1'b0; creq.stb <= 1'b0; creq.we <= 1'b0;
            ack_t    <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_RX_RD_CORE: begin
          if (c_ack_i) begin
            creq.cyc <= 1'b0; creq.stb <= 1'b0;
            mreq     <= '{cyc: 1'b1, stb: 1'b1, we: 1'b1, sel: WB_SEL_ALL, adr: rx_ptr, dat: c_dat_i};
            state    <= ST_RX_WR_MEM;
          end
        end
        ST_RX_WR_MEM: begin
          if (m_err_i) begin
            mreq.cyc <= 1'b0; mreq.stb <= 1'b0; mreq.we <= 1'b0; mreq.sel <= '0;
            err      <= 1'b1;
            state    <= ST_IDLE;
          end else if (m_ack_i) begin
            mreq.cyc <= 1'b0; mreq.stb <= 1'b0; mreq.we <= 1'b0; mreq.sel <= '0;
            ack_r    <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_HOLD;
        // One quiet cycle so the core can drop its level request.
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_adr_o     = mreq.adr;
  assign m_dat_o     = mreq.dat;
  assign m_we_o      = mreq.we;
  assign m_sel_o     = mreq.sel;
  assign m_stb_o     = mreq.stb;
  assign m_cyc_o     = mreq.cyc;
  assign c_adr_o     = creq.adr;
  assign c_dat_o     = creq.dat;
  assign c_we_o      = creq.we;
  assign c_stb_o     = creq.stb;
  assign c_cyc_o     = creq.cyc;
  assign dma_ack_t_o = ack_t;
  assign dma_ack_r_o = ack_r;
  assign err_o       = err;

endmodule

// File: tb/tb_irda_dma_ctrl.sv
// Directed bench for irda_dma_ctrl with a transaction-level expectation model.
// Latency: n/a.
// Backpressure: slave models ack one cycle after strobe plus a programmable wait.
module tb_irda_dma_ctrl;
  localparam int         LEN_W    = 16;
  localparam logic [3:0] FIFO_ADR = 4'h0;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b0;
  logic             tx_start_i = 1'b0, rx_start_i = 1'b0;
  logic [31:0]      tx_base_i = '0, rx_base_i = '0;
  logic [LEN_W-1:0] tx_len_i = '0, rx_len_i = '0;
  logic             dma_req_t_i, dma_req_r_i, dma_ack_t_o, dma_ack_r_o;
  logic [31:0]      m_adr_o, m_dat_o, m_dat_i;
  logic             m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i;
  logic [3:0]       m_sel_o, c_adr_o;
  logic [31:0]      c_dat_o, c_dat_i;
  logic             c_we_o, c_stb_o, c_cyc_o, c_ack_i;
  logic             tx_busy_o, rx_busy_o, tx_done_o, rx_done_o, err_o;

  always #5 wb_clk_i = ~wb_clk_i;

  irda_dma_ctrl #(.LEN_W(LEN_W), .FIFO_ADR(FIFO_ADR)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .tx_start_i(tx_start_i), .tx_base_i(tx_base_i), .tx_len_i(tx_len_i),
    .rx_start_i(rx_start_i), .rx_base_i(rx_base_i), .rx_len_i(rx_len_i),
    .dma_req_t_i(dma_req_t_i), .dma_req_r_i(dma_req_r_i),
    .dma_ack_t_o(dma_ack_t_o), .dma_ack_r_o(dma_ack_r_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .c_adr_o(c_adr_o), .c_dat_o(c_dat_o), .c_dat_i(c_dat_i), .c_we_o(c_we_o),
    .c_stb_o(c_stb_o), .c_cyc_o(c_cyc_o), .c_ack_i(c_ack_i),
    .tx_busy_o(tx_busy_o), .rx_busy_o(rx_busy_o), .tx_done_o(tx_done_o), .rx_done_o(rx_done_o),
    .err_o(err_o)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Memory content seen by TX reads: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  // ---------------- expectation model ----------------
  logic [31:0] exp_rd_adr[$], exp_core_wr[$], exp_mw_adr[$], exp_mw_dat[$];
  logic [31:0] rx_src[$], obs_rd_adr[$];
  int          ack_order[$];     // 1 = TX ack, 2 = RX ack
  int          tx_ack_cnt = 0, rx_ack_cnt = 0, tx_done_cnt = 0, rx_done_cnt = 0;
  int          m_txn_cnt = 0, c_txn_cnt = 0;
  logic [31:0] last_mw_adr = '0, last_mw_dat = '0;

  // Word i of a TX job: memory address (base & ~3) + 4i, core receives its content.
  task automatic model_tx(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_adr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
      exp_core_wr.push_back(mem_word((base & 32'hFFFF_FFFC) + 32'(4 * i)));
    end
  endtask

  // Word i of an RX job: FIFO word i lands at (base & ~3) + 4i.
  task automatic model_rx(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1, input int n);
    for (int i = 0; i < n; i++) begin
      rx_src.push_back(i == 0 ? w0 : w1);
      exp_mw_adr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
      exp_mw_dat.push_back(i == 0 ? w0 : w1);
    end
  endtask

  task automatic clear_model();
    exp_rd_adr.delete(); exp_core_wr.delete(); exp_mw_adr.delete(); exp_mw_dat.delete();
    rx_src.delete();
  endtask

  // ---------------- slave and core-request responders ----------------
  int m_wait = 0, c_wait = 0, err_on_read = 0, rd_seen = 0, m_cnt = 0, c_cnt = 0;
  int tx_want = 0, rx_want = 0;

  initial begin
    m_ack_i = 0; m_err_i = 0; m_dat_i = '0; c_ack_i = 0; c_dat_i = '0;
    dma_req_t_i = 0; dma_req_r_i = 0;
    forever begin
      @(posedge wb_clk_i); #1;
      m_ack_i = 0; m_err_i = 0; c_ack_i = 0;
      if (dma_ack_t_o && tx_want > 0) tx_want--;
      if (dma_ack_r_o && rx_want > 0) rx_want--;
      dma_req_t_i = (tx_want > 0);
      dma_req_r_i = (rx_want > 0);
      m_dat_i = mem_word(m_adr_o);
      if (m_stb_o) begin
        m_cnt++;
        if (m_cnt == m_wait + 1) begin
          if (!m_we_o) begin
            rd_seen++;
            if (rd_seen == err_on_read) m_err_i = 1; else m_ack_i = 1;
          end else m_ack_i = 1;
        end
      end else m_cnt = 0;
      if (c_stb_o) begin
        c_cnt++;
        if (c_cnt == c_wait + 1) begin
          c_ack_i = 1;
          if (!c_we_o) c_dat_i = (rx_src.size() > 0) ? rx_src.pop_front() : 32'hDEAD_BEEF;
        end
      end else c_cnt = 0;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic p_m_stb, p_m_hs, p_c_stb, p_c_hs, p_ack_t, p_ack_r;
    p_m_stb = 0; p_m_hs = 0; p_c_stb = 0; p_c_hs = 0; p_ack_t = 0; p_ack_r = 0;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i) begin
        p_m_stb = 0; p_m_hs = 0; p_c_stb = 0; p_c_hs = 0; p_ack_t = 0; p_ack_r = 0;
      end else begin
        if (m_stb_o) begin
          check("m_cyc_with_stb", m_cyc_o, 1'b1);
          check("m_sel_full", m_sel_o, 4'hF);
        end
        if (m_stb_o && m_ack_i) begin
          m_txn_cnt++;
          if (!m_we_o) begin
            obs_rd_adr.push_back(m_adr_o);
            if (exp_rd_adr.size() == 0) flag("m_rd_unexpected", $sformatf("read at 0x%0h", m_adr_o));
            else check("m_rd_adr", m_adr_o, exp_rd_adr.pop_front());
          end else begin
            last_mw_adr = m_adr_o; last_mw_dat = m_dat_o;
            if (exp_mw_adr.size() == 0) flag("m_wr_unexpected", $sformatf("write at 0x%0h", m_adr_o));
            else begin
              check("m_wr_adr", m_adr_o, exp_mw_adr.pop_front());
              check("m_wr_dat", m_dat_o, exp_mw_dat.pop_front());
            end
          end
        end
        if (c_stb_o) begin
          check("c_cyc_with_stb", c_cyc_o, 1'b1);
          check("c_adr_fifo", c_adr_o, FIFO_ADR);
        end
        if (c_stb_o && c_ack_i) begin
          c_txn_cnt++;
          if (c_we_o) begin
            if (exp_core_wr.size() == 0) flag("c_wr_unexpected", $sformatf("data 0x%0h", c_dat_o));
            else check("c_wr_dat", c_dat_o, exp_core_wr.pop_front());
          end
        end
        if (p_m_stb && !m_stb_o) check("m_stb_held_to_ack", p_m_hs, 1'b1);
        if (p_c_stb && !c_stb_o) check("c_stb_held_to_ack", p_c_hs, 1'b1);
        if (dma_ack_t_o) begin
          tx_ack_cnt++; ack_order.push_back(1);
          check("ack_t_one_cycle", {p_ack_t, dma_ack_r_o}, 2'b00);
        end
        if (dma_ack_r_o) begin
          rx_ack_cnt++; ack_order.push_back(2);
          check("ack_r_one_cycle", p_ack_r, 1'b0);
        end
        if (tx_done_o) tx_done_cnt++;
        if (rx_done_o) rx_done_cnt++;
        p_m_stb = m_stb_o; p_m_hs = m_ack_i | m_err_i;
        p_c_stb = c_stb_o; p_c_hs = c_ack_i;
        p_ack_t = dma_ack_t_o; p_ack_r = dma_ack_r_o;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_tx(input logic [31:0] base, input logic [LEN_W-1:0] len);
    tx_base_i = base; tx_len_i = len; tx_start_i = 1; tick(1); tx_start_i = 0;
  endtask

  task automatic start_rx(input logic [31:0] base, input logic [LEN_W-1:0] len);
    rx_base_i = base; rx_len_i = len; rx_start_i = 1; tick(1); rx_start_i = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_busy_o || rx_busy_o || m_stb_o || c_stb_o) && n < budget) begin
      tick(1); n++;
    end
    if (n >= budget) flag(name, "timeout waiting for channels to go idle");
    tick(4);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_m_adr"}, m_adr_o, 32'h0);
    check({name, "_m_dat"}, m_dat_o, 32'h0);
    check({name, "_c_dat"}, c_dat_o, 32'h0);
    check({name, "_ctrl"}, {dma_ack_t_o, dma_ack_r_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o, c_adr_o,
                            c_we_o, c_stb_o, c_cyc_o, tx_busy_o, rx_busy_o, tx_done_o, rx_done_o, err_o}, 21'h0);
  endtask

  initial begin
    int a0, d0, m0, c0, n;

    // Reset state
    tick(3);
    check_all_zero("reset");
    wb_rst_i = 1;
    tick(2);

    // TX normal: three words from 0x100
    obs_rd_adr.delete();
    model_tx(32'h100, 3);
    a0 = tx_ack_cnt; d0 = tx_done_cnt;
    start_tx(32'h100, 3);
    check("tx_busy_after_start", tx_busy_o, 1'b1);
    tx_want = 3;
    wait_idle("tx_normal_wait", 200);
    check("tx_normal_acks", tx_ack_cnt - a0, 3);
    check("tx_normal_done", tx_done_cnt - d0, 1);
    check("tx_normal_busy", tx_busy_o, 1'b0);
    check("tx_normal_rd_cnt", obs_rd_adr.size(), 3);
    if (obs_rd_adr.size() >= 3) begin
      check("tx_rd_adr0_lit", obs_rd_adr[0], 32'h100);
      check("tx_rd_adr1_lit", obs_rd_adr[1], 32'h104);
      check("tx_rd_adr2_lit", obs_rd_adr[2], 32'h108);
    end
    check("tx_normal_core_left", exp_core_wr.size(), 0);

    // RX normal: misaligned base, two FIFO words
    model_rx(32'h203, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2);
    a0 = rx_ack_cnt; d0 = rx_done_cnt;
    start_rx(32'h203, 2);
    rx_want = 2;
    wait_idle("rx_normal_wait", 200);
    check("rx_normal_acks", rx_ack_cnt - a0, 2);
    check("rx_normal_done", rx_done_cnt - d0, 1);
    check("rx_last_adr_lit", last_mw_adr, 32'h204);
    check("rx_last_dat_lit", last_mw_dat, 32'h5A5A_5A5A);
    check("rx_normal_mw_left", exp_mw_adr.size(), 0);

    // Contention: both requests in the same cycle, RX goes first
    model_tx(32'h500, 1);
    model_rx(32'h400, 32'h1111_2222, 32'h0, 1);
    start_tx(32'h500, 1);
    start_rx(32'h400, 1);
    ack_order.delete();
    tx_want = 1; rx_want = 1;
    wait_idle("contention_wait", 200);
    check("contention_ack_cnt", ack_order.size(), 2);
    if (ack_order.size() == 2) begin
      check("contention_first_rx", ack_order[0], 2);
      check("contention_then_tx", ack_order[1], 1);
    end
    check("contention_reqs_served", {tx_want[1:0], rx_want[1:0]}, 4'h0);

    // Memory error on the 2nd read of a 4-word TX job
    model_tx(32'h100, 4);
    err_on_read = rd_seen + 2;
    a0 = tx_ack_cnt; d0 = tx_done_cnt;
    start_tx(32'h100, 4);
    tx_want = 4;
    wait_idle("err_wait", 200);
    check("err_set", err_o, 1'b1);
    check("err_tx_busy", tx_busy_o, 1'b0);
    check("err_one_ack", tx_ack_cnt - a0, 1);
    check("err_no_done", tx_done_cnt - d0, 0);
    check("err_rd_left", exp_rd_adr.size(), 3);
    // Core keeps requesting on a disarmed channel: nothing may happen
    m0 = m_txn_cnt; c0 = c_txn_cnt; a0 = tx_ack_cnt;
    tick(12);
    check("unarmed_no_mem", m_txn_cnt - m0, 0);
    check("unarmed_no_ack", tx_ack_cnt - a0, 0);
    tx_want = 0; err_on_read = 0;
    clear_model();
    tick(2);

    // len=0 start: clears error, done next cycle, no bus traffic
    m0 = m_txn_cnt; c0 = c_txn_cnt;
    start_tx(32'h0, 0);
    check("len0_err_cleared", err_o, 1'b0);
    check("len0_done_pulse", tx_done_o, 1'b1);
    check("len0_not_busy", tx_busy_o, 1'b0);
    tick(1);
    check("len0_done_one_cycle", tx_done_o, 1'b0);
    check("len0_no_bus", (m_txn_cnt - m0) + (c_txn_cnt - c0), 0);

    // Address wrap at the top of memory
    obs_rd_adr.delete();
    model_tx(32'hFFFF_FFFC, 2);
    d0 = tx_done_cnt;
    start_tx(32'hFFFF_FFFC, 2);
    tx_want = 2;
    wait_idle("wrap_wait", 200);
    check("wrap_rd_cnt", obs_rd_adr.size(), 2);
    if (obs_rd_adr.size() >= 2) begin
      check("wrap_adr0_lit", obs_rd_adr[0], 32'hFFFF_FFFC);
      check("wrap_adr1_lit", obs_rd_adr[1], 32'h0000_0000);
    end
    check("wrap_done", tx_done_cnt - d0, 1);

    // Wait-stated slaves on both buses
    m_wait = 3; c_wait = 3;
    model_tx(32'h600, 2);
    model_rx(32'h700, 32'hCAFE_F00D, 32'h0, 1);
    a0 = tx_ack_cnt + rx_ack_cnt; d0 = tx_done_cnt + rx_done_cnt;
    start_tx(32'h600, 2);
    start_rx(32'h700, 1);
    tx_want = 2; rx_want = 1;
    wait_idle("wait_state_wait", 400);
    check("ws_acks", tx_ack_cnt + rx_ack_cnt - a0, 3);
    check("ws_dones", tx_done_cnt + rx_done_cnt - d0, 2);
    check("ws_queues_empty", exp_rd_adr.size() + exp_core_wr.size() + exp_mw_adr.size(), 0);
    m_wait = 0; c_wait = 0;

    // Asynchronous reset while writing the core FIFO
    model_tx(32'h300, 2);
    start_tx(32'h300, 2);
    tx_want = 2;
    n = 0;
    while (!(c_stb_o && c_we_o) && n < 50) begin tick(1); n++; end
    if (n >= 50) flag("arst_reach_wr_core", "core write phase never reached");
    a0 = tx_ack_cnt;
    #2 wb_rst_i = 0;
    #1 check_all_zero("arst");
    tick(2);
    wb_rst_i = 1;
    m0 = m_txn_cnt; c0 = c_txn_cnt;
    tick(20);
    check("post_rst_no_bus", (m_txn_cnt - m0) + (c_txn_cnt - c0), 0);
    check("post_rst_no_ack", tx_ack_cnt - a0, 0);
    check("post_rst_idle", tx_busy_o, 1'b0);
    tx_want = 0;
    clear_model();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
